// File: rtl/types.sv
// Shared DRAM interface widths and the arbiter state encoding.
package types;
  localparam int ADDRESS_LEN        = 32;
  localparam int BURST_ACCESS_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;
endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above ptr_i, wrapping.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest active request wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N)) begin
        sum = sum - (IW + 1)'(N);
      end
      idx = sum[IW-1:0];
      if (req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM burst port, one outstanding transaction, with watchdog.
module dram_arbiter
  import types::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0]                     req_we,
  input  logic [NUM_REQ*ADDRESS_LEN-1:0]         req_addr,
  input  logic [NUM_REQ*BURST_ACCESS_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [NUM_REQ-1:0]                     resp_valid,
  output logic [NUM_REQ-1:0]                     resp_done,
  output logic                                   resp_err,
  output logic [BURST_ACCESS_WIDTH-1:0]          resp_rdata,
  output logic [ADDRESS_LEN-1:0]                 addr,
  output logic                                   read_en,
  output logic                                   write_en,
  output logic [BURST_ACCESS_WIDTH-1:0]          wdata,
  input  logic                                   dram_ready,
  input  logic                                   dram_complete,
  input  logic [BURST_ACCESS_WIDTH-1:0]          rdata,
  input  logic                                   valid,
  output logic                                   busy,
  output logic                                   err_sticky
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

  arb_state_t                    state_q;
  logic [IW-1:0]                 rr_ptr_q, gnt_q, pick_idx, rr_ptr_d;
  logic                          pick_any, we_q;
  logic [ADDRESS_LEN-1:0]        addr_q;
  logic [BURST_ACCESS_WIDTH-1:0] wdata_q, resp_rdata_q;
  logic [WW-1:0]                 wd_q;
  logic [NUM_REQ-1:0]            req_ready_q, resp_valid_q, resp_done_q;
  logic                          resp_err_q, err_sticky_q, read_en_q, write_en_q;
  logic                          wait_rd, wait_wr, event_ok, spurious;

  logic [ADDRESS_LEN-1:0]        addr_arr  [NUM_REQ];
  logic [BURST_ACCESS_WIDTH-1:0] wdata_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDRESS_LEN +: ADDRESS_LEN];
      assign wdata_arr[gi] = req_wdata[gi*BURST_ACCESS_WIDTH +: BURST_ACCESS_WIDTH];
    end
  endgenerate

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_rr_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  // Only the event matching the pending command in WAIT is legal; anything else is flagged.
  assign wait_rd  = (state_q == WAIT) && !we_q;
  assign wait_wr  = (state_q == WAIT) && we_q;
  assign event_ok = (wait_rd && valid) || (wait_wr && dram_complete);
  assign spurious = (valid && !wait_rd) || (dram_complete && !wait_wr);
  assign rr_ptr_d = (gnt_q == IDX_LAST) ? '0 : gnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      wd_q         <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_done_q  <= '0;
      resp_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_done_q  <= '0;
      resp_err_q   <= 1'b0;
      if (spurious) err_sticky_q <= 1'b1;
      case (state_q)
        IDLE: if (pick_any) begin
          gnt_q                 <= pick_idx;
          we_q                  <= req_we[pick_idx];
          addr_q                <= addr_arr[pick_idx];
          wdata_q               <= wdata_arr[pick_idx];
          req_ready_q[pick_idx] <= 1'b1;
          read_en_q             <= ~req_we[pick_idx];
          write_en_q            <= req_we[pick_idx];
          state_q               <= ISSUE;
        end
        ISSUE: if (dram_ready) begin
          read_en_q  <= 1'b0;
          write_en_q <= 1'b0;
          wd_q       <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // A real event on the final watchdog cycle takes precedence over the timeout.
          if (event_ok || wd_q == WD_LAST) begin
            if (event_ok && !we_q) resp_rdata_q <= rdata;
            if (!event_ok) begin
              resp_err_q   <= 1'b1;
              err_sticky_q <= 1'b1;
            end
            resp_valid_q[gnt_q] <= ~we_q;
            resp_done_q[gnt_q]  <= we_q;
            state_q             <= RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        RESP: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_done  = resp_done_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign read_en    = read_en_q;
  assign write_en   = write_en_q;
  assign busy       = (state_q != IDLE);
  assign err_sticky = err_sticky_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with four requesters and a 16-cycle watchdog.
module tb_dram_arbiter;
  import types::*;
  localparam int N  = 4;
  localparam int AW = ADDRESS_LEN;
  localparam int BW = BURST_ACCESS_WIDTH;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0]        req_we = '0;
  logic [N*AW-1:0]     req_addr = '0;
  logic [N*BW-1:0]     req_wdata = '0;
  logic [N-1:0]        req_ready, resp_valid, resp_done;
  logic                resp_err, read_en, write_en, busy, err_sticky;
  logic [BW-1:0]       resp_rdata, wdata;
  logic [AW-1:0]       addr;
  logic                dram_ready = 1'b0;
  logic                dram_complete = 1'b0;
  logic [BW-1:0]       rdata = '0;
  logic                valid = 1'b0;

  int total = 0;
  int bad = 0;

  dram_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_done(resp_done),
    .resp_err(resp_err), .resp_rdata(resp_rdata),
    .addr(addr), .read_en(read_en), .write_en(write_en), .wdata(wdata),
    .dram_ready(dram_ready), .dram_complete(dram_complete), .rdata(rdata), .valid(valid),
    .busy(busy), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [BW-1:0] d);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*BW +: BW] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    total++; if ({read_en, write_en, resp_err, err_sticky} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {read_en, write_en, resp_err, err_sticky}); end
    total++; if (addr !== '0 || wdata !== '0 || resp_rdata !== '0) begin bad++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0", addr, wdata, resp_rdata); end
    rst = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_single_read();
    logic [BW-1:0] exp_d;
    exp_d = 64'hA5A5_A5A5_A5A5_A5A5;
    set_req(0, 1'b0, 32'h40, '0);
    req_valid = 4'b0001;
    dram_ready = 1'b1;
    tick();
    req_valid = '0;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rd_ready got=%b exp=0001", req_ready); end
    total++; if (read_en !== 1'b1 || write_en !== 1'b0 || addr !== 32'h40) begin bad++; $display("FAIL rd_cmd rd=%b wr=%b addr=%h exp=1 0 40", read_en, write_en, addr); end
    tick();
    total++; if (read_en !== 1'b0 || req_ready !== 4'b0) begin bad++; $display("FAIL rd_accept rd=%b ready=%b exp=0 0000", read_en, req_ready); end
    for (int i = 0; i < 4; i++) tick();
    total++; if (resp_valid !== 4'b0 || busy !== 1'b1) begin bad++; $display("FAIL rd_wait resp=%b busy=%b exp=0000 1", resp_valid, busy); end
    valid = 1'b1;
    rdata = exp_d;
    tick();
    valid = 1'b0;
    total++; if (resp_valid !== 4'b0001 || resp_err !== 1'b0) begin bad++; $display("FAIL rd_resp resp=%b err=%b exp=0001 0", resp_valid, resp_err); end
    total++; if (resp_rdata !== exp_d) begin bad++; $display("FAIL rd_data got=%h exp=%h", resp_rdata, exp_d); end
    rdata = '0;
    tick();
    total++; if (resp_valid !== 4'b0 || busy !== 1'b0 || resp_rdata !== exp_d) begin bad++; $display("FAIL rd_after resp=%b busy=%b data=%h", resp_valid, busy, resp_rdata); end
    $display("txn read req=0 addr=40 data=%h", resp_rdata);
  endtask

  task automatic test_single_write();
    logic [BW-1:0] p;
    p = 64'h0123_4567_89AB_CDEF;
    set_req(1, 1'b1, 32'h80, p);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wr_ready got=%b exp=0010", req_ready); end
    total++; if (write_en !== 1'b1 || read_en !== 1'b0 || wdata !== p) begin bad++; $display("FAIL wr_cmd wr=%b rd=%b wdata=%h exp=1 0 %h", write_en, read_en, wdata, p); end
    tick();
    tick();
    tick();
    dram_complete = 1'b1;
    tick();
    dram_complete = 1'b0;
    total++; if (resp_done !== 4'b0010 || resp_valid !== 4'b0 || resp_err !== 1'b0) begin bad++; $display("FAIL wr_resp done=%b valid=%b err=%b exp=0010 0000 0", resp_done, resp_valid, resp_err); end
    tick();
    total++; if (resp_done !== 4'b0 || err_sticky !== 1'b0) begin bad++; $display("FAIL wr_after done=%b sticky=%b exp=0000 0", resp_done, err_sticky); end
    $display("txn write req=1 wdata=%h", p);
  endtask

  task automatic test_contention();
    int cnt [N];
    logic [N-1:0] exp_g;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; set_req(i, 1'b0, 32'(32'h100 * i), '0); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    dram_ready = 1'b1;
    req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp_g = 4'(1 << (t % N));
      tick();
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL rr_grant t=%0d got=%b exp=%b", t, req_ready, exp_g); end
      for (int i = 0; i < N; i++) cnt[i] += int'(req_ready[i]);
      tick();
      for (int i = 0; i < N; i++) cnt[i] += int'(req_ready[i]);
      valid = 1'b1;
      rdata = 64'(t + 1);
      tick();
      valid = 1'b0;
      for (int i = 0; i < N; i++) cnt[i] += int'(req_ready[i]);
      total++; if (resp_valid !== exp_g || resp_rdata !== 64'(t + 1)) begin bad++; $display("FAIL rr_resp t=%0d got=%b/%h exp=%b/%h", t, resp_valid, resp_rdata, exp_g, 64'(t + 1)); end
      tick();
      for (int i = 0; i < N; i++) cnt[i] += int'(req_ready[i]);
      $display("txn rr t=%0d grant=%b", t, exp_g);
    end
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      total++; if (cnt[i] !== 2) begin bad++; $display("FAIL rr_count req=%0d got=%0d exp=2", i, cnt[i]); end
    end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL rr_sticky got=%b exp=0", err_sticky); end
  endtask

  task automatic test_issue_stall();
    int hi;
    hi = 0;
    set_req(2, 1'b0, 32'h200, '0);
    dram_ready = 1'b0;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL stall_ready got=%b exp=0100", req_ready); end
    for (int i = 0; i < 10; i++) begin hi += int'(read_en); tick(); end
    hi += int'(read_en);
    dram_ready = 1'b1;
    tick();
    total++; if (hi !== 11) begin bad++; $display("FAIL stall_len got=%0d exp=11", hi); end
    total++; if (read_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stall_accept rd=%b busy=%b exp=0 1", read_en, busy); end
    tick();
    total++; if (read_en !== 1'b0) begin bad++; $display("FAIL stall_once got=%b exp=0", read_en); end
    valid = 1'b1;
    rdata = 64'hDEAD_BEEF_0000_0002;
    tick();
    valid = 1'b0;
    total++; if (resp_valid !== 4'b0100) begin bad++; $display("FAIL stall_resp got=%b exp=0100", resp_valid); end
    tick();
    $display("txn stall req=2 read_en_cycles=%0d", hi);
  endtask

  task automatic test_timeout();
    set_req(3, 1'b1, 32'h300, 64'h3333);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL to_ready got=%b exp=1000", req_ready); end
    tick();
    for (int i = 0; i < 15; i++) tick();
    total++; if (resp_done !== 4'b0 || busy !== 1'b1 || err_sticky !== 1'b0) begin bad++; $display("FAIL to_early done=%b busy=%b sticky=%b", resp_done, busy, err_sticky); end
    tick();
    total++; if (resp_done !== 4'b1000 || resp_err !== 1'b1 || err_sticky !== 1'b1) begin bad++; $display("FAIL to_resp done=%b err=%b sticky=%b exp=1000 1 1", resp_done, resp_err, err_sticky); end
    tick();
    total++; if (resp_err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_after err=%b busy=%b exp=0 0", resp_err, busy); end
    $display("txn timeout req=3");
    // event on the exact watchdog expiry cycle
    set_req(0, 1'b0, 32'h44, '0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL to_next_ready got=%b exp=0001", req_ready); end
    tick();
    for (int i = 0; i < 15; i++) tick();
    valid = 1'b1;
    rdata = 64'h5A5A;
    tick();
    valid = 1'b0;
    total++; if (resp_valid !== 4'b0001 || resp_err !== 1'b0 || resp_rdata !== 64'h5A5A) begin bad++; $display("FAIL to_edge valid=%b err=%b data=%h exp=0001 0 5a5a", resp_valid, resp_err, resp_rdata); end
    tick();
    $display("txn edge req=0 data=%h", resp_rdata);
  endtask

  task automatic test_reset_mid_wait();
    set_req(1, 1'b0, 32'h11, '0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total++; if (busy !== 1'b0 || {req_ready, resp_valid, resp_done} !== 12'b0) begin bad++; $display("FAIL mid_rst_hs busy=%b ready=%b valid=%b done=%b", busy, req_ready, resp_valid, resp_done); end
    total++; if ({read_en, write_en, resp_err, err_sticky} !== 4'b0 || addr !== '0 || wdata !== '0 || resp_rdata !== '0) begin bad++; $display("FAIL mid_rst_out flags=%b addr=%h rdata=%h", {read_en, write_en, resp_err, err_sticky}, addr, resp_rdata); end
    valid = 1'b1;
    tick();
    valid = 1'b0;
    total++; if (err_sticky !== 1'b1 || busy !== 1'b0 || resp_valid !== 4'b0) begin bad++; $display("FAIL spurious sticky=%b busy=%b valid=%b exp=1 0 0000", err_sticky, busy, resp_valid); end
    req_valid = 4'b1111;
    tick();
    req_valid = '0;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL post_rst_grant got=%b exp=0001", req_ready); end
    $display("txn reset_mid_wait grant=%b", req_ready);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_issue_stall();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single DRAM burst port (addr/read_en/write_en/wdata in, dram_ready/dram_complete/rdata/valid out) between NUM_REQ requesters, e.g. several PIM memory controllers or a host loader plus the PIM engine.
- Round-robin, one outstanding DRAM transaction at a time, with a per-transaction watchdog.
- Sits between the requesters and dram, inside top_design.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, maximum number of WAIT cycles before the transaction is aborted.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester request; held until req_ready
- req_we  input  NUM_REQ  1 = write, 0 = read
- req_addr  input  NUM_REQ*ADDRESS_LEN  packed addresses; requester i occupies slice i
- req_wdata  input  NUM_REQ*BURST_ACCESS_WIDTH  packed write bursts
- req_ready  output  NUM_REQ  one-cycle accept pulse, one-hot
- resp_valid  output  NUM_REQ  one-cycle read-data pulse to the owner
- resp_done  output  NUM_REQ  one-cycle write-complete pulse to the owner
- resp_err  output  1  qualifies resp_valid/resp_done: transaction timed out
- resp_rdata  output  BURST_ACCESS_WIDTH  registered read burst, shared by all requesters
- addr  output  ADDRESS_LEN  to dram
- read_en  output  1  to dram
- write_en  output  1  to dram
- wdata  output  BURST_ACCESS_WIDTH  to dram
- dram_ready  input  1  dram accepts a command this cycle
- dram_complete  input  1  write-done pulse
- rdata  input  BURST_ACCESS_WIDTH  read burst
- valid  input  1  rdata valid pulse
- busy  output  1  state != IDLE
- err_sticky  output  1  set on timeout or on a spurious valid/dram_complete; cleared only by reset

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE; rr_ptr=0.
  - All outputs 0, including resp_rdata, addr and wdata.
  - An in-flight transaction is dropped with no response; reset mid-operation is legal and leaves nothing pending.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register g, we, addr and wdata from slice g.
  - Next cycle: state ISSUE and req_ready[g]=1 for exactly that cycle.
  - The requester may drop req_valid or change its fields after req_ready.
- ISSUE:
  - read_en = ~we_q and write_en = we_q, held high throughout ISSUE; addr and wdata driven from the registers.
  - The command is accepted in the cycle where (read_en|write_en) && dram_ready; next state WAIT, watchdog cleared.
- WAIT:
  - Read: wait for valid, then register rdata into resp_rdata.
  - Write: wait for dram_complete.
  - Either event moves to RESP.
  - The watchdog increments each WAIT cycle; at count == TIMEOUT_CYCLES-1 with no event, go to RESP with resp_err=1 and set err_sticky.
- RESP (one cycle):
  - Pulse resp_valid[g] (read) or resp_done[g] (write); resp_err is valid in the same cycle.
  - rr_ptr = (g+1) mod NUM_REQ.
  - Next state IDLE.
- Timing:
  - Read latency, request to resp_valid = 3 + DRAM latency cycles.
  - Minimum spacing between grants is 4 cycles.
  - resp_rdata holds its value until the next read response.
- Boundary cases:
  - Requests arriving during ISSUE/WAIT/RESP wait; they are never lost and never acknowledged early.
  - valid or dram_complete in IDLE/ISSUE/RESP, or of the wrong kind in WAIT: ignored, err_sticky set.
  - Event on the exact timeout cycle: the event wins, resp_err=0.
  - All requesters valid continuously: strict rotation 0,1,..,N-1,0; no starvation.
  - Single requester: served back-to-back.
  - rr_ptr wraps from NUM_REQ-1 to 0.
- Width rules:
  - Grant index width is $clog2(NUM_REQ) (minimum 1).
  - Watchdog width is $clog2(TIMEOUT_CYCLES)+1.

Decomposition:
- Package types (existing) holds ADDRESS_LEN and BURST_ACCESS_WIDTH; add the arb_state_t enum (IDLE, ISSUE, WAIT, RESP) there.
- One sub-module, rr_picker: combinational round-robin priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index and any-request flag.
  - Reused later for bank schedulers.

Test Plan:
- Single read: req 0, addr 0x40, dram returns valid with rdata=0xA5.. after 5 cycles -> req_ready[0] on cycle 1, read_en high from cycle 1 while dram_ready, resp_valid[0] with resp_rdata=0xA5.., resp_err=0.
- Single write: req 1, we=1, wdata pattern P, dram_complete after 3 cycles -> write_en with wdata=P, resp_done[1] pulse, no resp_valid.
- Contention: NUM_REQ=4, all req_valid held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each requester gets exactly 2 req_ready pulses.
- dram_ready low for 10 cycles in ISSUE -> read_en held 10+1 cycles; exactly one command accepted.
- Timeout: TIMEOUT_CYCLES=16 and dram never responds -> RESP after 16 WAIT cycles with resp_err=1; err_sticky=1; next request still served.
- Reset mid-WAIT, then a spurious valid after reset -> all outputs 0 and busy=0; spurious valid sets err_sticky; the next request is granted to requester 0 first.
